wb_stream_reader_ctrl: RTL and testbench
========================================

WB_STREAM_READER_CTRL -- requirements
Module: wb_stream_reader_ctrl

Interface
REQ-001 SHALL have parameter WB_AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, Wishbone/FIFO data width.
REQ-003 SHALL have parameter FIFO_AW, default 5, downstream FIFO depth = 2**FIFO_AW words.
REQ-004 SHALL have ports: wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 wbm_adr_o  out  WB_AW  master read address, byte-addressed.
REQ-007 wbm_sel_o  out  WB_DW/8  byte select, constant all ones.
REQ-008 wbm_we_o  out  1  constant 0 (read only).
REQ-009 wbm_cyc_o / wbm_stb_o  out  1 each  bus cycle / strobe.
REQ-010 wbm_cti_o  out  3  cycle type; wbm_bte_o  out  2  constant 2'b00.
REQ-011 wbm_dat_i  in  WB_DW  read data; wbm_ack_i  in  1  ack; wbm_err_i  in  1  error.
REQ-012 fifo_d_o  out  WB_DW  data to FIFO; fifo_wr_o  out  1  FIFO write strobe.
REQ-013 fifo_cnt_i  in  FIFO_AW+1  current FIFO occupancy in words.
REQ-014 enable_i  in  1  one-cycle start pulse from config block.
REQ-015 start_adr_i  in  WB_AW  buffer start byte address, word aligned.
REQ-016 buf_size_i  in  WB_AW  buffer length in bytes, multiple of 4.
REQ-017 burst_size_i  in  WB_AW  max burst length in words.
REQ-018 busy_o  out  1  transfer in progress; tx_cnt_o  out  WB_DW  words transferred.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_SPACE, BURST.
REQ-020 IDLE + enable_i=1: latch start_adr_i, buf_size_i>>2 (total words), burst_size_i; clear tx_cnt_o; busy_o=1 next cycle; go WAIT_SPACE.
REQ-021 enable_i while busy_o=1: ignored, latched config unchanged.
REQ-022 Total words = 0: WAIT_SPACE exits to IDLE after one cycle, busy_o high exactly one cycle, no bus cycle.
REQ-023 Burst length = min(latched burst size, remaining words); latched burst size 0 treated as 1.
REQ-024 WAIT_SPACE -> BURST when (2**FIFO_AW - fifo_cnt_i) >= burst length; otherwise stay, cyc/stb low.
REQ-025 BURST: cyc_o=stb_o=1 registered, asserted first cycle of BURST, held until final ack.
REQ-026 wbm_adr_o = latched start + 4*tx_cnt_o, advancing by 4 on each ack.
REQ-027 wbm_cti_o = 3'b010 on all beats except last of burst = 3'b111; single-beat burst = 3'b111; 3'b000 outside BURST.
REQ-028 Each cycle with ack_i=1 in BURST: fifo_wr_o=1 same cycle, fifo_d_o=wbm_dat_i (combinational), tx_cnt_o+1 next cycle.
REQ-029 fifo_wr_o=0 at all other times; never asserted without ack_i.
REQ-030 Final ack of burst: cyc/stb low next cycle; remaining words 0 -> IDLE, busy_o=0; else -> WAIT_SPACE.
REQ-031 wbm_err_i=1 in BURST: no FIFO write that cycle, cyc/stb low next cycle, -> IDLE, busy_o=0, tx_cnt_o holds count of good words.
REQ-032 ack_i/err_i outside BURST ignored.
REQ-033 tx_cnt_o width WB_DW, never exceeds total words; no wrap within a transfer.
REQ-034 Back-to-back bursts: at least one idle cycle (WAIT_SPACE) between cyc_o deassert and reassert.

Reset
REQ-035 wb_rst_ni=0 asynchronously forces: state IDLE, cyc/stb 0, cti 000, adr 0, busy_o 0, tx_cnt_o 0, fifo_wr_o 0, latched config 0.
REQ-036 Reset mid-burst: cyc_o drops without waiting for clock; after release block idles until next enable_i.

Verification
REQ-037 start=0x1000, buf=64 B, burst=4, FIFO empty, ack every cycle -> 4 bursts of 4, adr 0x1000..0x103C, cti 010,010,010,111 per burst, 16 fifo writes, tx_cnt_o=16, busy_o falls.
REQ-038 buf=24 B, burst=4 -> bursts of 4 then 2; second burst cti 010,111; tx_cnt_o=6.
REQ-039 FIFO_AW=5, fifo_cnt_i=30, burst=4 -> stays WAIT_SPACE, cyc_o low; set fifo_cnt_i=28 -> burst starts.
REQ-040 err_i on 3rd beat of first burst, buf=32 B -> 2 fifo writes, busy_o low, tx_cnt_o=2, cyc_o low next cycle.
REQ-041 buf=0 with enable -> busy_o high one cycle, no cyc_o; enable while busy -> no restart.
REQ-042 Assert wb_rst_ni=0 mid-burst between clock edges -> cyc_o, busy_o, tx_cnt_o zero immediately.

Source files
------------

// File: rtl/wb_stream_reader_ctrl.sv
// rtl/wb_stream_reader_ctrl.sv - Wishbone burst reader that streams a memory buffer into a downstream FIFO
module wb_stream_reader_ctrl #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [WB_DW-1:0]     fifo_d_o,
    output logic                 fifo_wr_o,
    input  logic [FIFO_AW:0]     fifo_cnt_i,
    input  logic                 enable_i,
    input  logic [WB_AW-1:0]     start_adr_i,
    input  logic [WB_AW-1:0]     buf_size_i,
    input  logic [WB_AW-1:0]     burst_size_i,
    output logic                 busy_o,
    output logic [WB_DW-1:0]     tx_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_BURST
    } state_t;

    localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    state_t             state_q, state_d;
    logic [WB_AW-1:0]   start_adr_q, start_adr_d;
    logic [WB_AW-1:0]   total_words_q, total_words_d;
    logic [WB_AW-1:0]   burst_size_q, burst_size_d;
    logic [WB_AW-1:0]   beats_left_q, beats_left_d;
    logic [WB_DW-1:0]   tx_cnt_q, tx_cnt_d;
    logic               cyc_q, cyc_d;

    logic [WB_AW-1:0]   tx_cnt_aw;
    logic [WB_AW-1:0]   remaining;
    logic [WB_AW-1:0]   burst_eff;
    logic [WB_AW-1:0]   next_len;
    logic [WB_AW-1:0]   fifo_space;
    logic               in_burst;
    logic               last_beat;
    logic               good_ack;

    // Derived quantities: words left, next burst length and free FIFO room
    always_comb begin
        tx_cnt_aw  = WB_AW'(tx_cnt_q);
        remaining  = total_words_q - tx_cnt_aw;
        burst_eff  = (burst_size_q == '0) ? WB_AW'(1) : burst_size_q;
        next_len   = (burst_eff < remaining) ? burst_eff : remaining;
        fifo_space = (fifo_cnt_i >= FIFO_DEPTH) ? '0 : WB_AW'(FIFO_DEPTH - fifo_cnt_i);
        in_burst   = (state_q == ST_BURST);
        last_beat  = (beats_left_q == WB_AW'(1));
        good_ack   = in_burst && wbm_ack_i && !wbm_err_i;
    end

    // Output decode; read data passes straight through to the FIFO on an ack
    always_comb begin
        wbm_adr_o = start_adr_q + (tx_cnt_aw << 2);
        wbm_sel_o = '1;
        wbm_we_o  = 1'b0;
        wbm_cyc_o = cyc_q;
        wbm_stb_o = cyc_q;
        wbm_bte_o = 2'b00;
        wbm_cti_o = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
        fifo_d_o  = wbm_dat_i;
        fifo_wr_o = good_ack;
        busy_o    = (state_q != ST_IDLE);
        tx_cnt_o  = tx_cnt_q;
    end

    // Next-state logic: start on enable, wait for FIFO room, run one burst at a time
    always_comb begin
        state_d       = state_q;
        start_adr_d   = start_adr_q;
        total_words_d = total_words_q;
        burst_size_d  = burst_size_q;
        beats_left_d  = beats_left_q;
        tx_cnt_d      = tx_cnt_q;
        cyc_d         = cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    start_adr_d   = start_adr_i;
                    total_words_d = buf_size_i >> 2;
                    burst_size_d  = burst_size_i;
                    tx_cnt_d      = '0;
                    state_d       = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (remaining == '0) begin
                    state_d = ST_IDLE;
                end else if (fifo_space >= next_len) begin
                    beats_left_d = next_len;
                    cyc_d        = 1'b1;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wbm_err_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (wbm_ack_i) begin
                    tx_cnt_d     = tx_cnt_q + WB_DW'(1);
                    beats_left_d = beats_left_q - WB_AW'(1);
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        state_d = (remaining == WB_AW'(1)) ? ST_IDLE : ST_WAIT_SPACE;
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= ST_IDLE;
            start_adr_q   <= '0;
            total_words_q <= '0;
            burst_size_q  <= '0;
            beats_left_q  <= '0;
            tx_cnt_q      <= '0;
            cyc_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_adr_q   <= start_adr_d;
            total_words_q <= total_words_d;
            burst_size_q  <= burst_size_d;
            beats_left_q  <= beats_left_d;
            tx_cnt_q      <= tx_cnt_d;
            cyc_q         <= cyc_d;
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb/tb_wb_stream_reader_ctrl.sv - randomized self-checking bench for wb_stream_reader_ctrl
module tb_wb_stream_reader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] fifo_d_o;
    logic        fifo_wr_o;
    logic [5:0]  fifo_cnt_i;
    logic        enable_i;
    logic [31:0] start_adr_i, buf_size_i, burst_size_i;
    logic        busy_o;
    logic [31:0] tx_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stream_reader_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(5)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_cti_o    (wbm_cti_o),
        .wbm_bte_o    (wbm_bte_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i),
        .fifo_d_o     (fifo_d_o),
        .fifo_wr_o    (fifo_wr_o),
        .fifo_cnt_i   (fifo_cnt_i),
        .enable_i     (enable_i),
        .start_adr_i  (start_adr_i),
        .buf_size_i   (buf_size_i),
        .burst_size_i (burst_size_i),
        .busy_o       (busy_o),
        .tx_cnt_o     (tx_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: the expected beat list is precomputed from the burst-splitting rule,
    // the bench acts as a randomly stalling slave and predicts cyc from FIFO room.
    task automatic run_xfer(input logic [31:0] start, input int words, input int bs,
                            input int err_at, input int ack_pct, input int fmode);
        logic [31:0] exp_adr[$];
        logic [2:0]  exp_cti[$];
        logic [31:0] dat;
        int bs_eff, rem, len, idx, tx_exp, nwr, space, exp_wr;
        bit expect_cyc, finished, done, is_err, is_ack;
        bs_eff = (bs == 0) ? 1 : bs;
        rem = words;
        while (rem > 0) begin
            len = (bs_eff < rem) ? bs_eff : rem;
            for (int j = 0; j < len; j++) begin
                exp_adr.push_back(start + 32'(4 * (words - rem + j)));
                exp_cti.push_back((j == len - 1) ? 3'b111 : 3'b010);
            end
            rem -= len;
        end
        start_adr_i  = start;
        buf_size_i   = 32'(words * 4);
        burst_size_i = 32'(bs);
        fifo_cnt_i   = '0;
        enable_i     = 1'b1;
        tick();
        enable_i = 1'b0;
        idx = 0; tx_exp = 0; nwr = 0;
        expect_cyc = 1'b0; finished = 1'b0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            check("tx_cnt", tx_cnt_o, tx_exp);
            check("cyc", wbm_cyc_o, expect_cyc);
            check("stb", wbm_stb_o, expect_cyc);
            if (finished) begin
                check("busy_end", busy_o, 0);
                done = 1'b1;
            end else begin
                check("busy", busy_o, 1);
                case (fmode)
                    0: fifo_cnt_i = '0;
                    1: fifo_cnt_i = ($urandom % 2 == 0) ? 6'($urandom_range(0, 32)) : 6'($urandom_range(0, 8));
                    default: fifo_cnt_i = (c < 6) ? 6'd30 : 6'd28;
                endcase
                enable_i     = (words == 0) || ($urandom % 8 == 0);
                start_adr_i  = $urandom;
                buf_size_i   = $urandom;
                burst_size_i = $urandom;
                if (wbm_cyc_o) begin
                    if (idx >= exp_adr.size()) begin
                        check("beat_overrun", 64'(idx), 64'(exp_adr.size()));
                        finished = 1'b1;
                        expect_cyc = 1'b0;
                    end else begin
                        check("adr", wbm_adr_o, exp_adr[idx]);
                        check("cti", wbm_cti_o, exp_cti[idx]);
                        is_err = (idx == err_at);
                        is_ack = is_err ? bit'($urandom % 2) : ($urandom_range(0, 99) < ack_pct);
                        dat = $urandom;
                        wbm_dat_i = dat;
                        wbm_ack_i = is_ack;
                        wbm_err_i = is_err;
                        #1;
                        check("fifo_wr", fifo_wr_o, is_ack && !is_err);
                        if (is_err) begin
                            finished = 1'b1;
                            expect_cyc = 1'b0;
                        end else if (is_ack) begin
                            check("fifo_d", fifo_d_o, dat);
                            nwr++;
                            tx_exp++;
                            if (exp_cti[idx] == 3'b111) begin
                                expect_cyc = 1'b0;
                                if (idx + 1 == words) finished = 1'b1;
                            end else begin
                                expect_cyc = 1'b1;
                            end
                            idx++;
                        end else begin
                            expect_cyc = 1'b1;
                        end
                    end
                end else begin
                    check("cti_idle", wbm_cti_o, 0);
                    wbm_ack_i = ($urandom % 4 == 0);
                    wbm_err_i = ($urandom % 4 == 0);
                    wbm_dat_i = $urandom;
                    #1;
                    check("fifo_wr_idle", fifo_wr_o, 0);
                    if (idx >= words) begin
                        finished = 1'b1;
                        expect_cyc = 1'b0;
                    end else begin
                        len = (bs_eff < words - idx) ? bs_eff : words - idx;
                        space = 32 - int'(fifo_cnt_i);
                        expect_cyc = (space >= len);
                    end
                end
                tick();
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                enable_i  = 1'b0;
            end
        end
        exp_wr = (err_at >= 0 && err_at < words) ? err_at : words;
        check("xfer_done", 64'(done), 1);
        check("fifo_writes", 64'(nwr), 64'(exp_wr));
    endtask

    initial begin
        int words, bs, err_at;
        rst_n = 1'b0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        fifo_cnt_i = '0; enable_i = 1'b0;
        start_adr_i = '0; buf_size_i = '0; burst_size_i = '0;
        #23;
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx", tx_cnt_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_cti", wbm_cti_o, 0);
        check("rst_wr", fifo_wr_o, 0);
        check("sel", wbm_sel_o, 4'hF);
        check("we", wbm_we_o, 0);
        check("bte", wbm_bte_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset pulled in the middle of a burst, between clock edges
        start_adr_i = 32'h2000; buf_size_i = 32; burst_size_i = 8; enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        tick();
        check("mid_cyc_up", wbm_cyc_o, 1);
        wbm_ack_i = 1'b1;
        tick();
        tick();
        wbm_ack_i = 1'b0;
        check("mid_tx", tx_cnt_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", wbm_cyc_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_tx", tx_cnt_o, 0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_cyc", wbm_cyc_o, 0);
            check("post_rst_busy", busy_o, 0);
        end

        run_xfer(32'h1000, 16, 4, -1, 100, 0);
        run_xfer(32'h1000, 6, 4, -1, 100, 0);
        run_xfer(32'h4000, 8, 4, -1, 100, 2);
        run_xfer(32'h5000, 8, 4, 2, 100, 0);
        run_xfer(32'h6000, 0, 4, -1, 100, 0);
        run_xfer(32'h7000, 5, 0, -1, 100, 0);
        run_xfer(32'h8000, 3, 1, 0, 100, 0);

        for (int t = 0; t < 40; t++) begin
            words  = $urandom_range(0, 40);
            bs     = $urandom_range(0, 10);
            err_at = ($urandom % 4 == 0) ? $urandom_range(0, words) : -1;
            run_xfer($urandom & 32'hFFFF_FFFC, words, bs, err_at,
                     $urandom_range(30, 100), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
